// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, threshold flags, read-valid strobe and sticky error flags.
//
// Parameters:
//    WIDTH     data width in bits (>=1)
//    DEPTH     number of entries, power of two, >=2
//    AF_THRESH almost_full asserted when count >= AF_THRESH
//    AE_THRESH almost_empty asserted when count <= AE_THRESH
//
// Ports:
//    clk          clock, all state updates on the rising edge
//    reset        synchronous active-high reset
//    wr_en, din   write request and write data
//    rd_en        read request
//    dout, valid  registered read data and its one-cycle valid strobe
//    count        occupancy 0..DEPTH
//    full, empty, almost_full, almost_empty  decodes of count
//    overflow, underflow  sticky rejected-write / rejected-read flags
//    err_clr      clears overflow/underflow (a same-cycle set wins)
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
   logic             wr_acc, rd_acc;

   assign full         = count_q == DEPTH_C;
   assign empty        = count_q == '0;
   assign almost_full  = count_q >= AF_C;
   assign almost_empty = count_q <= AE_C;

   // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
   assign wr_acc = wr_en && (!full || rd_en);
   assign rd_acc = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                 (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
      dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
      valid_d  = rd_acc;
      ovf_d    = (wr_en && full && !rd_en) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
      unf_d    = (rd_en && empty) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; a write blocked by reset must not land either.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) mem_q[wr_ptr_q] <= din;
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
endmodule
